// File: rtl/uart_pkg.sv
// Shared types and constants for the 5-byte UART command link
// (0x55 0x5A CMD DATA_H DATA_L). The transmit side reuses the header constants.
package uart_pkg;

  // Bit-level receive engine states
  typedef enum logic [2:0] {
    BS_IDLE,
    BS_START,
    BS_DATA,
    BS_PARITY,
    BS_STOP
  } bit_state_t;

  // Frame-level header hunt / field capture states
  typedef enum logic [2:0] {
    FS_HUNT,
    FS_GOT_HDR0,
    FS_CMD,
    FS_DH,
    FS_DL
  } frame_state_t;

  localparam logic [7:0] HDR0_DEFAULT = 8'h55;
  localparam logic [7:0] HDR1_DEFAULT = 8'h5A;

  // Clock cycles per serial bit (truncating integer division)
  function automatic int unsigned bit_cyc(input int unsigned clk_hz, input int unsigned bps);
    return clk_hz / bps;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Byte receiver: 2-flop input synchroniser plus start/data/parity/stop bit engine.
// Delivers one-cycle byte_valid or err pulses, registered one cycle after the stop sample.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYC   = 434,
  parameter string       CHECK_BIT = "None"
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rxd,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_err
);

  localparam bit          PAR_EN   = (CHECK_BIT != "None");
  localparam bit          PAR_ODD  = (CHECK_BIT == "Odd");
  localparam int unsigned HALF_CYC = BIT_CYC / 2;
  localparam int          CNT_W    = $clog2(BIT_CYC + 1);

  logic             sync1_q, sync2_q, prev_q;
  bit_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic half_done, bit_done, par_ok, fall_edge;

  assign half_done = (cnt_q == CNT_W'(HALF_CYC - 1));
  assign bit_done  = (cnt_q == CNT_W'(BIT_CYC - 1));
  assign fall_edge = prev_q && !sync2_q;
  // Odd: ones over data+parity is odd; Even: it is even; always OK without parity
  assign par_ok    = !PAR_EN || ((^{shift_q, par_q}) == PAR_ODD);

  // Synchroniser and edge-detect history, idle-high out of reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= i_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Bit engine state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= BS_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Bit engine next state: sample mid-bit, LSB first; back to IDLE at stop midpoint
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      BS_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (fall_edge) state_d = BS_START;
      end
      BS_START: begin
        if (half_done) begin
          cnt_d   = '0;
          // a line already back high at mid-start is a glitch
          state_d = sync2_q ? BS_IDLE : BS_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BS_DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PAR_EN ? BS_PARITY : BS_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BS_PARITY: begin
        if (bit_done) begin
          cnt_d   = '0;
          par_d   = sync2_q;
          state_d = BS_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BS_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = BS_IDLE;
          if (sync2_q && par_ok) begin
            valid_d = 1'b1;
            byte_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = BS_IDLE;
    endcase
  end

  assign o_byte       = byte_q;
  assign o_byte_valid = valid_q;
  assign o_err        = err_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver: hunts for the two header bytes, captures CMD/DATA_H/DATA_L,
// and aborts a frame on a byte error or an inter-byte timeout.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK         = 50_000_000,
  parameter int unsigned BPS         = 115200,
  parameter string       CHECK_BIT   = "None",
  parameter logic [7:0]  HDR0        = HDR0_DEFAULT,
  parameter logic [7:0]  HDR1        = HDR1_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 50_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rxd,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  output logic [7:0]  o_cmd,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_err
);

  localparam int unsigned BIT_CYC = bit_cyc(CLK, BPS);
  localparam int          TO_W    = $clog2(TIMEOUT_CYC + 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  uart_rx_byte #(
    .BIT_CYC   (BIT_CYC),
    .CHECK_BIT (CHECK_BIT)
  ) u_rx_byte (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rxd        (i_rxd),
    .o_byte       (rx_byte),
    .o_byte_valid (rx_valid),
    .o_err        (rx_err)
  );

  frame_state_t    fstate_q, fstate_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      dh_q, dh_d;
  logic [7:0]      out_cmd_q, out_cmd_d;
  logic [15:0]     out_data_q, out_data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] idle_q, idle_d;
  logic            timeout_hit;

  // Timeout fires when the idle count would reach TIMEOUT_CYC inside a frame
  assign timeout_hit = (fstate_q != FS_HUNT) && !rx_valid &&
                       (idle_q == TO_W'(TIMEOUT_CYC - 1));

  // Frame state and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fstate_q   <= FS_HUNT;
      cmd_q      <= '0;
      dh_q       <= '0;
      out_cmd_q  <= '0;
      out_data_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      idle_q     <= '0;
    end else begin
      fstate_q   <= fstate_d;
      cmd_q      <= cmd_d;
      dh_q       <= dh_d;
      out_cmd_q  <= out_cmd_d;
      out_data_q <= out_data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      idle_q     <= idle_d;
    end
  end

  // Frame next state: errors and timeouts share one o_err pulse and force HUNT
  always_comb begin
    fstate_d   = fstate_q;
    cmd_d      = cmd_q;
    dh_d       = dh_q;
    out_cmd_d  = out_cmd_q;
    out_data_d = out_data_q;
    valid_d    = 1'b0;
    err_d      = rx_err || timeout_hit;
    idle_d     = (fstate_q == FS_HUNT || rx_valid) ? '0 : idle_q + TO_W'(1);
    if (rx_err || timeout_hit) begin
      fstate_d = FS_HUNT;
      idle_d   = '0;
    end else if (rx_valid) begin
      case (fstate_q)
        FS_HUNT: begin
          if (rx_byte == HDR0) fstate_d = FS_GOT_HDR0;
        end
        FS_GOT_HDR0: begin
          // a repeated HDR0 may be the real start of the header
          if (rx_byte == HDR1)      fstate_d = FS_CMD;
          else if (rx_byte == HDR0) fstate_d = FS_GOT_HDR0;
          else                      fstate_d = FS_HUNT;
        end
        FS_CMD: begin
          cmd_d    = rx_byte;
          fstate_d = FS_DH;
        end
        FS_DH: begin
          dh_d     = rx_byte;
          fstate_d = FS_DL;
        end
        FS_DL: begin
          out_cmd_d  = cmd_q;
          out_data_d = {dh_q, rx_byte};
          valid_d    = 1'b1;
          fstate_d   = FS_HUNT;
        end
        default: fstate_d = FS_HUNT;
      endcase
    end
  end

  assign o_byte       = rx_byte;
  assign o_byte_valid = rx_valid;
  assign o_cmd        = out_cmd_q;
  assign o_data       = out_data_q;
  assign o_valid      = valid_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: table-driven frames plus hand-written
// corner sequences (timeout, bad stop bit, glitch, parity, mid-frame reset).
module tb_uart_frame_rx;

  localparam int CLK_HZ  = 50_000_000;
  localparam int BAUD    = 1_000_000;
  localparam int BIT_CYC = 50;
  localparam int TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        srst;
  logic        rxd_a, rxd_b;
  logic [7:0]  byte_a, cmd_a, byte_b, cmd_b;
  logic [15:0] data_a, data_b;
  logic        bv_a, val_a, err_a, bv_b, val_b, err_b;

  always #5 clk = ~clk;

  uart_frame_rx #(
    .CLK(CLK_HZ), .BPS(BAUD), .CHECK_BIT("None"),
    .HDR0(8'h55), .HDR1(8'h5A), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_reset(srst), .i_rxd(rxd_a),
    .o_byte(byte_a), .o_byte_valid(bv_a), .o_cmd(cmd_a),
    .o_data(data_a), .o_valid(val_a), .o_err(err_a)
  );

  uart_frame_rx #(
    .CLK(CLK_HZ), .BPS(BAUD), .CHECK_BIT("Even"),
    .HDR0(8'h55), .HDR1(8'h5A), .TIMEOUT_CYC(TIMEOUT)
  ) dut_par (
    .i_clk(clk), .i_reset(srst), .i_rxd(rxd_b),
    .o_byte(byte_b), .o_byte_valid(bv_b), .o_cmd(cmd_b),
    .o_data(data_b), .o_valid(val_b), .o_err(err_b)
  );

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled on the falling edge
  int cyc = 0, nbv_a = 0, nval_a = 0, nerr_a = 0, overlap = 0;
  int last_bv_cyc = 0, err_dist = 0, nbv_b = 0, nerr_b = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!srst) begin
      if (bv_a) begin nbv_a <= nbv_a + 1; last_bv_cyc <= cyc; end
      if (val_a) nval_a <= nval_a + 1;
      if (err_a) begin nerr_a <= nerr_a + 1; err_dist <= cyc - last_bv_cyc; end
      if (val_a && err_a) overlap <= overlap + 1;
      if (bv_b) nbv_b <= nbv_b + 1;
      if (err_b) nerr_b <= nerr_b + 1;
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired, got running required finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input int which, input logic v);
    if (which == 0) rxd_a = v; else rxd_b = v;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input logic stop_v,
                           input bit with_par, input logic par_v);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, b[i]);
    if (with_par) drive_bit(which, par_v);
    drive_bit(which, stop_v);
  endtask

  typedef struct {
    logic [63:0] bytes;     // byte k at [8k +: 8]
    int          n;
    int          exp_bv;
    int          exp_valid;
    logic [7:0]  exp_cmd;
    logic [15:0] exp_data;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t vecs [5];
  int   b_bv, b_val, b_err;

  initial begin
    vecs[0] = '{64'h0000_0084_D302_5A55, 5, 5, 1, 8'h02, 16'hD384, 8'h84};
    vecs[1] = '{64'h0000_3412_075A_5555, 6, 6, 1, 8'h07, 16'h1234, 8'h34};
    vecs[2] = '{64'h0000_0055_5A55_5A55, 5, 5, 1, 8'h55, 16'h5A55, 8'h55};
    vecs[3] = '{64'h0000_0000_0000_3412, 2, 2, 0, 8'h55, 16'h5A55, 8'h34};
    vecs[4] = '{64'h00EF_BEA0_5A55_1255, 7, 7, 1, 8'hA0, 16'hBEEF, 8'hEF};

    srst = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_byte", {24'd0, byte_a}, 0);
    chk("rst_flags", {29'd0, bv_a, val_a, err_a}, 0);
    chk("rst_cmd", {24'd0, cmd_a}, 0);
    chk("rst_data", {16'd0, data_a}, 0);
    $display("reset: byte=%0h cmd=%0h data=%0h", byte_a, cmd_a, data_a);
    srst = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      b_bv = nbv_a; b_val = nval_a; b_err = nerr_a;
      for (int k = 0; k < vecs[v].n; k++)
        send_byte(0, vecs[v].bytes[8*k +: 8], 1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_bytes", v), nbv_a - b_bv, vecs[v].exp_bv);
      chk($sformatf("v%0d_valid", v), nval_a - b_val, vecs[v].exp_valid);
      chk($sformatf("v%0d_err", v), nerr_a - b_err, 0);
      chk($sformatf("v%0d_cmd", v), {24'd0, cmd_a}, {24'd0, vecs[v].exp_cmd});
      chk($sformatf("v%0d_data", v), {16'd0, data_a}, {16'd0, vecs[v].exp_data});
      chk($sformatf("v%0d_last", v), {24'd0, byte_a}, {24'd0, vecs[v].exp_last});
      $display("vec %0d: %0d bytes -> cmd=%0h data=%0h valid=%0d", v, vecs[v].n,
               cmd_a, data_a, nval_a - b_val);
    end

    // Inter-byte timeout after CMD, trailing bytes land in HUNT
    b_bv = nbv_a; b_val = nval_a; b_err = nerr_a;
    send_byte(0, 8'h55, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h5A, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h02, 1'b1, 1'b0, 1'b0);
    rxd_a = 1'b1;
    repeat (TIMEOUT + 400) @(negedge clk);
    send_byte(0, 8'hD3, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h84, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("to_bytes", nbv_a - b_bv, 5);
    chk("to_err", nerr_a - b_err, 1);
    chk("to_valid", nval_a - b_val, 0);
    chk("to_dist_ok", {31'd0, (err_dist >= TIMEOUT && err_dist <= TIMEOUT + 2)}, 1);
    chk("to_cmd_hold", {24'd0, cmd_a}, 32'hA0);
    chk("to_data_hold", {16'd0, data_a}, 32'hBEEF);
    $display("timeout: err=%0d dist=%0d valid=%0d", nerr_a - b_err, err_dist, nval_a - b_val);

    // Stop bit forced low inside a frame, then a clean frame
    b_bv = nbv_a; b_val = nval_a; b_err = nerr_a;
    send_byte(0, 8'h55, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h5A, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h33, 1'b0, 1'b0, 1'b0);
    rxd_a = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);
    chk("stop_err", nerr_a - b_err, 1);
    chk("stop_nobyte", nbv_a - b_bv, 2);
    send_byte(0, 8'h55, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h5A, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h01, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h00, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'hFF, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("stop_valid", nval_a - b_val, 1);
    chk("stop_err_once", nerr_a - b_err, 1);
    chk("stop_cmd", {24'd0, cmd_a}, 32'h01);
    chk("stop_data", {16'd0, data_a}, 32'h00FF);
    $display("stop0: err=%0d then cmd=%0h data=%0h", nerr_a - b_err, cmd_a, data_a);

    // Short low glitch (well under half a bit)
    b_bv = nbv_a; b_err = nerr_a;
    rxd_a = 1'b0;
    repeat (10) @(negedge clk);
    rxd_a = 1'b1;
    repeat (12 * BIT_CYC) @(negedge clk);
    chk("glitch_bytes", nbv_a - b_bv, 0);
    chk("glitch_err", nerr_a - b_err, 0);
    $display("glitch: bytes=%0d err=%0d", nbv_a - b_bv, nerr_a - b_err);

    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    b_bv = nbv_b; b_err = nerr_b;
    send_byte(1, 8'h07, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("par_bad_err", nerr_b - b_err, 1);
    chk("par_bad_nobyte", nbv_b - b_bv, 0);
    send_byte(1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    chk("par_good_byte", nbv_b - b_bv, 1);
    chk("par_good_err", nerr_b - b_err, 1);
    chk("par_good_val", {24'd0, byte_b}, 32'h07);
    $display("parity: err=%0d bytes=%0d byte=%0h", nerr_b - b_err, nbv_b - b_bv, byte_b);

    // Reset during bit 4 of DATA_H
    b_err = nerr_a;
    send_byte(0, 8'h55, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h5A, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h07, 1'b1, 1'b0, 1'b0);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    rxd_a = 1'b0;
    repeat (BIT_CYC / 2) @(negedge clk);
    srst = 1'b1; rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_byte", {24'd0, byte_a}, 0);
    chk("mrst_flags", {29'd0, bv_a, val_a, err_a}, 0);
    chk("mrst_cmd", {24'd0, cmd_a}, 0);
    chk("mrst_data", {16'd0, data_a}, 0);
    srst = 1'b0;
    repeat (12 * BIT_CYC) @(negedge clk);
    b_val = nval_a;
    send_byte(0, 8'h55, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h5A, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h3C, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h12, 1'b1, 1'b0, 1'b0);
    send_byte(0, 8'h34, 1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("mrst_noerr", nerr_a - b_err, 0);
    chk("mrst_valid", nval_a - b_val, 1);
    chk("mrst_cmd2", {24'd0, cmd_a}, 32'h3C);
    chk("mrst_data2", {16'd0, data_a}, 32'h1234);
    $display("midreset: cmd=%0h data=%0h valid=%0d", cmd_a, data_a, nval_a - b_val);

    chk("valid_err_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Receive side of the 5-byte UART command link: 0x55 0x5A CMD DATA_H DATA_L, 8N1 at 115200 baud, 50 MHz clock.
- Deserialises the serial line and hunts for the 0x55 0x5A header.
- Delivers CMD and a 16-bit data word as a single-cycle valid pulse.
- Sits at the far end of the link (e.g. gimbal/servo board or loopback test harness) and feeds the downstream command decoder.

Parameters:
- CLK, 50_000_000, system clock frequency in Hz.
- BPS, 115200, baud rate; BIT_CYC = CLK/BPS (434 at defaults), integer division, truncated.
- CHECK_BIT, "None", parity mode: "None", "Odd" or "Even"; must match the transmitter.
- HDR0, 8'h55, first header byte.
- HDR1, 8'h5A, second header byte.
- TIMEOUT_CYC, 50_000, maximum idle cycles between bytes of one frame (1 ms at defaults).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rxd  in  1  asynchronous serial input, idle high.
- o_byte  out  8  last received byte.
- o_byte_valid  out  1  one-cycle pulse per correctly received byte.
- o_cmd  out  8  CMD field of the last good frame; holds until the next good frame.
- o_data  out  16  {DATA_H, DATA_L} of the last good frame; holds until the next good frame.
- o_valid  out  1  one-cycle pulse when a complete frame is accepted.
- o_err  out  1  one-cycle pulse on framing error, parity error or inter-byte timeout inside a frame.

Behaviour:
- One clock (i_clk). Reset is synchronous and active-high (i_reset).
- Reset values:
  - all outputs 0;
  - bit state IDLE; frame state HUNT;
  - counters 0;
  - synchroniser flops 1.
- i_reset asserted mid-byte or mid-frame discards everything with no o_err pulse.
- i_rxd passes through a 2-flop synchroniser, initialised high. All sampling uses the synchronised signal.
- Bit engine states: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
  - IDLE: a falling edge (previous 1, current 0) enters START with the bit counter cleared.
  - START: at BIT_CYC/2, line high means glitch, return to IDLE silently; line low advances to DATA.
  - DATA: each bit is sampled every BIT_CYC cycles, LSB first, 8 bits.
  - PARITY (only when CHECK_BIT is not "None"): Odd means the count of ones over data plus parity is odd; Even means it is even.
  - STOP: sampled at mid-bit. Stop=1 with parity OK pulses o_byte_valid and updates o_byte on the cycle after the sample, then returns to IDLE. Otherwise o_err pulses and no byte is delivered.
- IDLE is re-entered at the stop-bit midpoint, so a start edge arriving half a bit later is caught; back-to-back bytes work.
- Frame FSM (advances on o_byte_valid only): HUNT, GOT_HDR0, CMD, DH, DL.
  - HUNT: HDR0 -> GOT_HDR0.
  - GOT_HDR0: HDR1 -> CMD; HDR0 -> stay in GOT_HDR0; any other byte -> HUNT.
  - CMD: latch cmd -> DH.
  - DH: latch data high byte -> DL.
  - DL: latch data low byte. o_cmd/o_data update and o_valid pulses exactly 1 cycle after the o_byte_valid of DATA_L. Return to HUNT.
  - Payload bytes equal to 0x55 or 0x5A are data, not headers.
- Inter-byte timeout: the idle counter resets on every o_byte_valid and counts only while the frame FSM is not in HUNT. Reaching TIMEOUT_CYC pulses o_err and forces HUNT.
- A byte error (framing or parity) while the FSM is not in HUNT forces HUNT. The o_err pulse is the same single pulse; it never double-pulses.
- A frame error and a timeout in the same cycle give a single o_err pulse.
- o_valid and o_err are never asserted in the same cycle.

Decomposition:
- Shared package uart_pkg: frame-state enum, bit-state enum, HDR0/HDR1 defaults, and the BIT_CYC calculation function. The transmit side reuses the header constants.
- One sub-module, uart_rx_byte: synchroniser plus bit engine. Outputs byte, valid and err.
- The top holds the frame FSM and the timeout counter.

Test Plan:
- Defaults; drive 55 5A 02 D3 84 back-to-back at 434 cycles/bit -> five o_byte_valid pulses, one o_valid; o_cmd=8'h02, o_data=16'hD384; o_err never high.
- Drive 55 55 5A 07 12 34 -> resync through the repeated header; o_valid with o_cmd=8'h07, o_data=16'h1234.
- Drive 55 5A 02, then idle 60_000 cycles, then D3 84 -> one o_err pulse at idle counter = 50_000; no o_valid; the trailing bytes are ignored in HUNT.
- Byte with stop bit forced 0 inside a frame -> o_err pulse, no o_byte_valid; a following clean 55 5A 01 00 FF gives o_valid, o_data=16'h00FF.
- 100-cycle low glitch on i_rxd -> no o_byte_valid, no o_err. CHECK_BIT="Even" with a wrong parity bit -> o_err.
- Assert i_reset during bit 4 of DH -> all outputs 0. A fresh full frame afterwards decodes correctly.
